// File: rtl/aes_enc_core_if.sv
// Host/key-controller bundle for aes_enc_core: block request, round-key
// handshake and result/status signals.
interface aes_enc_core_if;
    logic         start;
    logic [127:0] plaintext;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] ciphertext;
    logic         done;
    logic         busy;
    logic         abort;

    modport master (
        output start, plaintext, key_ready, round_key,
        input  round, ciphertext, done, busy, abort
    );

    modport slave (
        input  start, plaintext, key_ready, round_key,
        output round, ciphertext, done, busy, abort
    );
endinterface

// File: rtl/aes_enc_core.sv
// Iterative AES-256 encryption core: one FIPS-197 round per round period,
// with round keys supplied by an external key controller after KEY_LAT cycles.
module aes_enc_core #(
    parameter int unsigned KEY_LAT = 2
) (
    input  logic           clk,
    input  logic           srst_n,
    aes_enc_core_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_KEY, FETCH, DONE} state_e;
    typedef logic [15:0][7:0] blk_t;

    localparam logic [2:0] LAT = 3'(KEY_LAT);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block (column-major, r + 4c) lives at packed element 15-i.
    function automatic blk_t sub_shift(input blk_t s);
        blk_t o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[4'(15 - (r + 4*c))] = sbox(s[4'(15 - (r + 4*((c + r) % 4)))]);
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_cols(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4*c)];
            a1 = s[4'(14 - 4*c)];
            a2 = s[4'(13 - 4*c)];
            a3 = s[4'(12 - 4*c)];
            o[4'(15 - 4*c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4'(14 - 4*c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4'(13 - 4*c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4'(12 - 4*c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [2:0]   cnt_q, cnt_d;
    blk_t         blk_q, blk_d;
    logic [127:0] ct_q, ct_d;
    logic         abort_q, abort_d;

    blk_t         sr_w, mc_w;
    logic [127:0] rnd_out_w;

    always_comb begin
        sr_w = sub_shift(blk_q);
        mc_w = mix_cols(sr_w);
        if (round_q == 4'd0) begin
            rnd_out_w = blk_q ^ bus.round_key;
        end else if (round_q == 4'd14) begin
            rnd_out_w = sr_w ^ bus.round_key;
        end else begin
            rnd_out_w = mc_w ^ bus.round_key;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ct_d    = ct_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                round_d = '0;
                cnt_d   = '0;
                if (bus.start) begin
                    blk_d   = bus.plaintext;
                    state_d = bus.key_ready ? FETCH : WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (bus.key_ready) begin
                    round_d = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!bus.key_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == LAT) begin
                    blk_d = rnd_out_w;
                    cnt_d = '0;
                    if (round_q == 4'd14) begin
                        // Round drops to 0 here so index 14 is held exactly one round period.
                        ct_d    = rnd_out_w;
                        round_d = '0;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                round_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            ct_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ct_q    <= ct_d;
            abort_q <= abort_d;
        end
    end

    assign bus.round      = round_q;
    assign bus.ciphertext = ct_q;
    assign bus.done       = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.abort      = abort_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// Scoreboard bench for aes_enc_core: FIPS-197 C.3 AES-256 vector, wait-for-key,
// ignored/back-to-back start, abort and asynchronous reset scenarios.
module tb_aes_enc_core;

    localparam int unsigned KL = 2;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int unsigned LATENCY = 15 * (KL + 1) + 1;

    typedef struct {
        logic [1:0]   kind;   // 2'b01 done, 2'b10 abort
        logic [127:0] ct;
        int unsigned  due;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    exp_t        sb[$];

    logic [127:0] rk_tab [16];
    logic [3:0]   rpipe [KL];

    aes_enc_core_if bus ();

    aes_enc_core #(.KEY_LAT(KL)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key controller model: round key follows the round index after KL cycles.
    always @(posedge clk) begin
        rpipe[0] <= bus.round;
        for (int i = 1; i < KL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.round_key = rk_tab[rpipe[KL-1]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [127:0] ct, input int unsigned due);
        exp_t e;
        e.kind = kind;
        e.ct   = ct;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(name, 128'(sb.size()), '0);
    endtask

    task automatic wait_round(input logic [3:0] r, input string name);
        int unsigned n;
        n = 0;
        while (bus.round != r && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(bus.round), 128'(r));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (srst_n && (bus.done || bus.abort)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 128'({bus.abort, bus.done}), '0);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 128'({bus.abort, bus.done}), 128'(e.kind));
                chk("event_cycle", 128'(cyc), 128'(e.due));
                chk("ciphertext", bus.ciphertext, e.ct);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        rk_tab[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        rk_tab[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        rk_tab[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        rk_tab[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        rk_tab[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        rk_tab[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        rk_tab[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        rk_tab[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        rk_tab[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        rk_tab[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        rk_tab[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        rk_tab[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        rk_tab[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        rk_tab[15] = '0;

        bus.start     = 1'b0;
        bus.plaintext = '0;
        bus.key_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), '0);
        chk("rst_done", 128'(bus.done), '0);
        chk("rst_abort", 128'(bus.abort), '0);
        chk("rst_round", 128'(bus.round), '0);
        chk("rst_ct", bus.ciphertext, '0);
        srst_n = 1'b1;

        // C.3 vector with round trace, ignored starts mid-op and in DONE, back-to-back start.
        @(negedge clk);
        bus.plaintext = PT;
        bus.start     = 1'b1;
        push(2'b01, CT, cyc + LATENCY);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            if (k == 9) begin
                bus.start     = 1'b1;
                bus.plaintext = '1;
            end
            if (k == 10) begin
                bus.start     = 1'b0;
                bus.plaintext = PT;
            end
            chk("trace_round", 128'(bus.round), 128'(k / 3));
            chk("trace_busy", 128'(bus.busy), 128'(1));
            if (k == 20) chk("ct_hidden_first", bus.ciphertext, '0);
        end
        @(negedge clk);
        chk("done_cycle_busy", 128'(bus.busy), 128'(1));
        bus.start = 1'b1;
        @(negedge clk);
        chk("idle_after_done_busy", 128'(bus.busy), '0);
        chk("idle_after_done_round", 128'(bus.round), '0);
        push(2'b01, CT, cyc + LATENCY);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ct_held_mid_op", bus.ciphertext, CT);
        drain("drain_back_to_back");

        // Start before key_ready: WAIT_KEY must hold until the key arrives.
        bus.key_ready = 1'b0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 || i == 19) begin
                chk("wait_key_busy", 128'(bus.busy), 128'(1));
                chk("wait_key_round", 128'(bus.round), '0);
            end
        end
        bus.key_ready = 1'b1;
        push(2'b01, CT, cyc + LATENCY);
        drain("drain_wait_key");

        // Abort: key_ready drops during round 7.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_round(4'd7, "reach_round7");
        bus.key_ready = 1'b0;
        push(2'b10, CT, cyc + 1);
        @(negedge clk);
        chk("abort_idle_busy", 128'(bus.busy), '0);
        @(negedge clk);
        chk("after_abort_round", 128'(bus.round), '0);
        chk("after_abort_ct", bus.ciphertext, CT);
        bus.key_ready = 1'b1;
        drain("drain_abort");

        // Asynchronous reset pulse between edges during round 5.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_round(4'd5, "reach_round5");
        #1 srst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(bus.busy), '0);
        chk("arst_done", 128'(bus.done), '0);
        chk("arst_abort", 128'(bus.abort), '0);
        chk("arst_round", 128'(bus.round), '0);
        chk("arst_ct", bus.ciphertext, '0);
        #1 srst_n = 1'b1;
        repeat (60) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        push(2'b01, CT, cyc + LATENCY);
        @(negedge clk);
        bus.start = 1'b0;
        drain("drain_after_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 The module SHALL have parameter KEY_LAT, default 2, giving the cycles from a change on round to a valid round_key from the key controller (legal values 1..7).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port srst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to encrypt plaintext.
REQ-005 The module SHALL have port plaintext, input, 128 bits: the input block, byte 0 in bits [127:120].
REQ-006 The module SHALL have port key_ready, input, 1 bit: the key controller's expanded-key-valid flag.
REQ-007 The module SHALL have port round_key, input, 128 bits: the key controller's round key for the current round.
REQ-008 The module SHALL have port round, output, 4 bits: round index 0..14 driven to the key controller.
REQ-009 The module SHALL have port ciphertext, output, 128 bits: the encrypted block.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse, ciphertext valid.
REQ-011 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The module SHALL have port abort, output, 1 bit: one-cycle pulse, operation cancelled.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_KEY, FETCH and DONE, and SHALL perform AES-256 encryption per FIPS-197: 14 rounds, with one round applied per round period.
REQ-014 In IDLE, start=1 with key_ready=1 SHALL latch plaintext into the state register, set round=0 and wait counter=0, and move to FETCH.
REQ-015 In IDLE, start=1 with key_ready=0 SHALL latch plaintext and move to WAIT_KEY, which SHALL move to FETCH (round=0, counter=0) on the first cycle key_ready=1.
REQ-016 In FETCH, the counter SHALL increment each cycle; when counter==KEY_LAT, the round SHALL be applied to the state register and counter SHALL clear.
REQ-017 Each round index SHALL therefore be held for exactly KEY_LAT+1 cycles.
REQ-018 Round 0 SHALL apply AddRoundKey only.
REQ-019 Rounds 1..13 SHALL apply SubBytes, ShiftRows, MixColumns and then AddRoundKey.
REQ-020 Round 14 SHALL apply SubBytes, ShiftRows and AddRoundKey, with no MixColumns.
REQ-021 After applying rounds 0..13, round SHALL increment by 1; after applying round 14, the FSM SHALL load ciphertext and move to DONE.
REQ-022 MixColumns SHALL use GF(2^8) xtime with polynomial 0x11B; all byte arithmetic SHALL be 8-bit XOR with no carries.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Latency SHALL be exactly 15*(KEY_LAT+1)+1 cycles from the start-sampling edge to the done-high cycle when key_ready=1 at start (46 cycles at KEY_LAT=2).
REQ-025 ciphertext SHALL hold its value until the next completed operation; the state register SHALL NOT be visible on ciphertext mid-operation.
REQ-026 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-027 start in the first IDLE cycle after DONE SHALL be accepted.
REQ-028 key_ready=0 sampled in FETCH SHALL move the FSM to IDLE, pulse abort for one cycle, leave done=0 and leave ciphertext unchanged.
REQ-029 round SHALL read 0 in IDLE and WAIT_KEY, and SHALL never exceed 14.

Reset
REQ-030 srst_n=0 SHALL immediately, without waiting for clk, force IDLE, round=0, counter=0, ciphertext=0, state register=0, done=0, busy=0 and abort=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; no done or abort SHALL follow.
REQ-032 The first start after srst_n deasserts SHALL be honoured on the next clock edge.

Verification
REQ-033 FIPS-197 C.3: key controller loaded with 000102...1e1f, plaintext 00112233445566778899aabbccddeeff, start with key_ready=1 -> done 46 cycles later, ciphertext 8ea2b7ca516745bfeafc49904b496089.
REQ-034 Round trace: during the REQ-033 run -> round steps 0..14, each value held 3 cycles; busy=1 throughout; done exactly one pulse.
REQ-035 Start before key_ready: start with key_ready=0, key_ready rises 20 cycles later -> WAIT_KEY held; done 46 cycles after key_ready rises; same ciphertext as REQ-033.
REQ-036 Back-to-back and ignored start: start pulsed at cycle 10 of an operation -> no effect; start on the first IDLE cycle after done -> second correct ciphertext after 46 more cycles.
REQ-037 Abort: key_ready dropped during round 7 -> abort pulse 1 cycle, FSM in IDLE, ciphertext equals the previous result, no done.
REQ-038 Asynchronous reset: srst_n pulsed low between clock edges during round 5 -> outputs zero before the next edge; no done afterwards; a fresh start reproduces REQ-033.
